// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned MAX_BEATS_DEF = 16;

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester and FIFO write-port signals of the arbiter, bundled for port passing.
interface fifo_wr_arb_if #(
  parameter int unsigned NREQ  = fifo_arb_pkg::NREQ_DEF,
  parameter type         dat_t = logic [7:0]
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0] req_put;
  dat_t            req_data [NREQ];
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_rdy;
  dat_t            wdata;
  logic            wput;
  logic            wrdy;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic            err_ovr;

  modport master (
    input  req_put, req_data, req_last, wrdy,
    output req_rdy, wdata, wput, gnt_vld, gnt_id, err_ovr
  );

  modport slave (
    output req_put, req_data, req_last, wrdy,
    input  req_rdy, wdata, wput, gnt_vld, gnt_id, err_ovr
  );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = fifo_arb_pkg::NREQ_DEF
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    found_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);

  localparam int unsigned IDW = $clog2(NREQ);

  int unsigned    pos;
  logic [IDW-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = IDW'(pos);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-atomic round-robin arbiter muxing NREQ requesters onto one FIFO write port.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter type         dat_t     = logic [7:0],
  parameter int unsigned MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic           wclk,
  input  logic           wrst_n,
  fifo_wr_arb_if.master  bus
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(MAX_BEATS + 1);

  arb_state_e     state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] gnt_id_q;
  logic [CW-1:0]  cnt_q;
  logic           err_q;

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] next_ptr;
  logic           xfer;
  logic           last_beat;
  logic           cap_beat;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (bus.req_put),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_id)
  );

  assign xfer      = (state_q == GRANT) && bus.req_put[gnt_id_q] && bus.wrdy;
  assign last_beat = bus.req_last[gnt_id_q];
  assign cap_beat  = (cnt_q == CW'(MAX_BEATS - 1));
  assign next_ptr  = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_id_q <= pick_id;
            cnt_q    <= '0;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
            // A last beat on the cap boundary is a normal end, not an overrun.
            if (last_beat || cap_beat) begin
              state_q <= IDLE;
              ptr_q   <= next_ptr;
              err_q   <= !last_beat;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write port follows the owner's handshake directly so a beat needs no extra stage.
  always_comb begin
    bus.wput    = 1'b0;
    bus.wdata   = dat_t'('0);
    bus.req_rdy = '0;
    if (state_q == GRANT) begin
      bus.wput              = bus.req_put[gnt_id_q];
      bus.wdata             = bus.req_data[gnt_id_q];
      bus.req_rdy[gnt_id_q] = bus.wrdy;
    end
  end

  assign bus.gnt_vld = (state_q == GRANT);
  assign bus.gnt_id  = gnt_id_q;
  assign bus.err_ovr = err_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: transaction-level owner/pointer model feeds expected beats to a monitor.
module tb_fifo_wr_arb;

  localparam int unsigned N  = fifo_arb_pkg::NREQ_DEF;
  localparam int unsigned MB = fifo_arb_pkg::MAX_BEATS_DEF;
  typedef logic [7:0] dat_t;

  typedef struct packed {
    int   cyc;
    int   id;
    dat_t d;
  } exp_t;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_wr_arb_if #(.NREQ(N), .dat_t(dat_t)) bus ();

  fifo_wr_arb #(.NREQ(N), .dat_t(dat_t), .MAX_BEATS(MB)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  // Pending beats per requester: bit 8 = last, bits 7:0 = payload.
  logic [8:0] rq [N][$];
  exp_t       sb [$];

  int   cyc = 0;
  int   cur_owner = -1, nxt_owner = -1;
  int   cur_ptr = 0, nxt_ptr = 0;
  int   cur_cnt = 0, nxt_cnt = 0;
  bit   cur_err = 1'b0, nxt_err = 1'b0;
  int   pop_id = -1;
  bit   mdl_on = 1'b0;
  bit   gen_on = 1'b0;
  int   put_pct = 100, wrdy_pct = 100;

  task automatic load(input int id, input int len, input int base, input bit with_last);
    for (int b = 0; b < len; b++)
      rq[id].push_back({with_last && (b == len - 1), dat_t'(base + b)});
  endtask

  task automatic gen_pkt(input int id);
    int len;
    len = $urandom_range(1, MB + 4);
    for (int b = 0; b < len; b++) begin
      dat_t v;
      v = dat_t'($urandom);
      rq[id].push_back({b == len - 1, v});
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: commit model state, drive fresh inputs, predict the coming edge.
  task automatic step();
    logic p [N];
    dat_t d [N];
    logic l [N];
    logic wr;
    exp_t e;
    @(posedge wclk); #1;
    cur_owner = nxt_owner; cur_ptr = nxt_ptr; cur_cnt = nxt_cnt; cur_err = nxt_err;
    if (pop_id >= 0) void'(rq[pop_id].pop_front());
    pop_id = -1;
    cyc++;
    wr = ($urandom_range(99) < wrdy_pct);
    for (int i = 0; i < N; i++) begin
      if (gen_on && rq[i].size() == 0 && $urandom_range(99) < 30) gen_pkt(i);
      if (rq[i].size() > 0) begin
        p[i] = ($urandom_range(99) < put_pct);
        d[i] = rq[i][0][7:0];
        l[i] = rq[i][0][8];
      end else begin
        p[i] = 1'b0;
        d[i] = dat_t'($urandom);
        l[i] = 1'($urandom);
      end
      bus.req_put[i]  = p[i];
      bus.req_data[i] = d[i];
      bus.req_last[i] = l[i];
    end
    bus.wrdy = wr;

    nxt_owner = cur_owner; nxt_ptr = cur_ptr; nxt_cnt = cur_cnt; nxt_err = 1'b0;
    if (cur_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (cur_ptr + k) % N;
        if (p[c]) begin
          nxt_owner = c;
          nxt_cnt   = 0;
          break;
        end
      end
    end else if (p[cur_owner] && wr) begin
      e.cyc = cyc; e.id = cur_owner; e.d = d[cur_owner];
      sb.push_back(e);
      pop_id  = cur_owner;
      nxt_cnt = cur_cnt + 1;
      if (l[cur_owner] || nxt_cnt == MB) begin
        nxt_owner = -1;
        nxt_ptr   = (cur_owner + 1) % N;
        nxt_err   = !l[cur_owner];
      end
    end
  endtask

  task automatic run_drain(input int limit);
    int n;
    n = 0;
    while (n < limit && !(all_empty() && cur_owner < 0 && nxt_owner < 0)) begin
      step();
      n++;
    end
    chk("drain_done", int'(all_empty() && nxt_owner < 0), 1);
  endtask

  logic [N-1:0] exp_rdy;
  exp_t         got_e;

  always @(negedge wclk) begin
    if (mdl_on) begin
      exp_rdy = '0;
      if (cur_owner >= 0 && bus.wrdy) exp_rdy[cur_owner] = 1'b1;
      chk("gnt_vld", int'(bus.gnt_vld), int'(cur_owner >= 0));
      if (cur_owner >= 0) chk("gnt_id", int'(bus.gnt_id), cur_owner);
      chk("err_ovr", int'(bus.err_ovr), int'(cur_err));
      chk("req_rdy", int'(bus.req_rdy), int'(exp_rdy));
      if (bus.wput && bus.wrdy) begin
        chk("beat_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          got_e = sb.pop_front();
          chk("beat_cycle", cyc, got_e.cyc);
          chk("beat_owner", int'(bus.gnt_id), got_e.id);
          chk("beat_data", int'(bus.wdata), int'(got_e.d));
        end
      end
    end
  end

  initial begin
    int n;
    bus.req_put  = '1;
    bus.req_last = '0;
    bus.wrdy     = 1'b1;
    for (int i = 0; i < N; i++) bus.req_data[i] = dat_t'(8'h11 * (i + 1));

    repeat (3) @(negedge wclk);
    chk("rst_gnt_vld", int'(bus.gnt_vld), 0);
    chk("rst_wput", int'(bus.wput), 0);
    chk("rst_req_rdy", int'(bus.req_rdy), 0);
    chk("rst_err_ovr", int'(bus.err_ovr), 0);
    chk("rst_gnt_id", int'(bus.gnt_id), 0);
    bus.req_put = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    mdl_on = 1'b1;

    // single requester, three-beat packet
    load(0, 3, 8'hA0, 1'b1);
    run_drain(50);

    // every requester holding one-beat packets
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) load(i, 1, 8'h10 * i + r, 1'b1);
    run_drain(100);

    // atomic packet under backpressure with a competing requester
    load(1, 4, 8'hB0, 1'b1);
    load(2, 2, 8'hD0, 1'b1);
    wrdy_pct = 40;
    run_drain(200);
    wrdy_pct = 100;

    // overlong stream forces a release at the beat cap
    load(3, 20, 8'h30, 1'b0);
    rq[3][19][8] = 1'b1;
    load(0, 1, 8'h50, 1'b1);
    load(1, 1, 8'h51, 1'b1);
    load(2, 1, 8'h52, 1'b1);
    run_drain(200);

    // randomized traffic
    gen_on = 1'b1; put_pct = 80; wrdy_pct = 70;
    repeat (3000) step();
    gen_on = 1'b0; put_pct = 100; wrdy_pct = 100;
    run_drain(2000);
    @(negedge wclk);
    chk("scoreboard_empty", sb.size(), 0);

    // reset during the second beat of a four-beat packet
    mdl_on = 1'b0;
    load(2, 4, 8'hC0, 1'b1);
    n = 0;
    while (n < 40 && sb.size() < 2) begin
      step();
      n++;
    end
    chk("mid_pkt_reached", int'(sb.size() >= 2), 1);
    #1;
    chk("pre_rst_wput", int'(bus.wput), 1);
    wrst_n = 1'b0;
    #1;
    chk("async_rst_wput", int'(bus.wput), 0);
    chk("async_rst_gnt_vld", int'(bus.gnt_vld), 0);
    chk("async_rst_req_rdy", int'(bus.req_rdy), 0);
    sb.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    bus.req_put  = '0;
    bus.req_put[0]     = 1'b1;
    bus.req_put[N - 1] = 1'b1;
    bus.req_last = '0;
    @(negedge wclk);
    chk("rst_hold_gnt_vld", int'(bus.gnt_vld), 0);
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    chk("post_rst_gnt_vld", int'(bus.gnt_vld), 1);
    chk("post_rst_gnt_id", int'(bus.gnt_id), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the FIFO write port; legal range 2..8.
REQ-002 Parameter dat_t, default logic [7:0]: beat payload type; identical to the FIFO write data type.
REQ-003 Parameter MAX_BEATS, default 16: maximum number of beats per packet before a forced release.
REQ-004 wclk  in  1  single clock for the whole block; all logic is rising-edge.
REQ-005 wrst_n  in  1  asynchronous, active-low reset.
REQ-006 req_put  in  NREQ  per-requester beat valid.
REQ-007 req_data  in  NREQ x dat_t  per-requester beat payload.
REQ-008 req_last  in  NREQ  marks the final beat of a packet; qualified by req_put.
REQ-009 req_rdy  out  NREQ  per-requester beat accept.
REQ-010 wdata  out  dat_t  payload to the FIFO write port.
REQ-011 wput  out  1  beat valid to the FIFO write port.
REQ-012 wrdy  in  1  FIFO not full; a beat transfers on a rising edge when wput and wrdy are both 1.
REQ-013 gnt_vld  out  1  a requester currently owns the port.
REQ-014 gnt_id  out  $clog2(NREQ)  index of the owning requester; meaningful only when gnt_vld is 1.
REQ-015 err_ovr  out  1  one-cycle pulse on a forced release.

Function
REQ-016 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-017 In IDLE the block SHALL drive wput=0, req_rdy=0 and gnt_vld=0.
- If any req_put bit is 1, the winner is the first set bit scanning upward, with wrap, from pointer ptr.
- The winner is registered into gnt_id, and the FSM enters GRANT on the next edge (one-cycle arbitration latency).
REQ-018 In GRANT the block SHALL drive the following combinationally from the registered gnt_id:
- wput=req_put[gnt_id]
- wdata=req_data[gnt_id]
- req_rdy[gnt_id]=wrdy
- all other req_rdy bits 0
- gnt_vld=1
REQ-019 Grant SHALL be held for a whole packet; if the owner deasserts req_put mid-packet, grant is retained and wput=0.
REQ-020 Other requesters SHALL never be granted while the owner's packet is open.
REQ-021 A transfer with req_last[gnt_id]=1 SHALL end the packet, as follows:
- the FSM returns to IDLE;
- ptr becomes (gnt_id+1) mod NREQ;
- this gives one idle bubble between back-to-back packets.
REQ-022 A beat counter SHALL behave as follows:
- width $clog2(MAX_BEATS+1);
- cleared on entry to GRANT;
- incremented on each transfer.
REQ-023 A transfer that is the MAX_BEATS-th beat of a packet without req_last SHALL trigger a forced release:
- err_ovr=1 for exactly the following cycle;
- the FSM returns to IDLE and ptr advances as in REQ-021;
- remaining beats of that requester are treated as a new packet on its next grant.
REQ-024 With wrdy=0 in GRANT, no transfer SHALL occur and counter, state and ptr SHALL hold.
REQ-025 A simultaneous last beat and forced-release condition SHALL count as a normal end, with err_ovr=0.
REQ-026 Inputs of non-owning requesters SHALL have no effect on any output or state.

Reset
REQ-027 While wrst_n=0, and asynchronously upon its assertion, the block SHALL force the following:
- FSM=IDLE
- ptr=0, gnt_id=0, beat counter=0
- err_ovr=0, wput=0, req_rdy=0, gnt_vld=0
REQ-028 A reset asserted mid-packet SHALL abandon the packet with no further transfer, and the first grant after release SHALL start from ptr=0.

Structure
REQ-029 A shared package fifo_arb_pkg SHALL hold:
- the FSM state enum (IDLE, GRANT);
- the NREQ and MAX_BEATS default constants.
REQ-030 Round-robin selection SHALL be a separate combinational sub-module rr_pick.
- Inputs: request vector and ptr.
- Outputs: found flag and winner index.

Verification
REQ-031 Single requester: req 0 sends 3-beat packet A0,A1,A2 with wrdy=1 -> wput high 3 cycles from the cycle after req_put; FIFO receives A0,A1,A2 in order; gnt_id=0; FSM back in IDLE after A2.
REQ-032 Round-robin: all 4 requesters hold 1-beat packets continuously -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-033 Atomicity and backpressure: req 1 sends 4 beats; wrdy=0 for 3 cycles after beat 2; req 2 requests throughout -> no req 2 beat is interleaved; req 1 beats 3-4 follow once wrdy returns; req 2 is granted next.
REQ-034 Forced release: MAX_BEATS=16; req 3 sends 20 beats with no last -> err_ovr pulses once after beat 16; FSM goes to IDLE; req 3 is re-granted for beats 17-20 after other requesters are served.
REQ-035 Reset mid-packet: wrst_n pulled low during beat 2 of a 4-beat packet -> wput=0 and gnt_vld=0 immediately; after release a request from req 0 is granted first.
